// File: rtl/mem_access_ctrl.sv
// Load/store access controller in front of a word-wide Data_Memory: byte/half/word requests,
// read-modify-write for sub-word stores, extended load data. Optional address checking: MEM_ADDR_CHECK_EN.
module mem_access_ctrl #(
   parameter int unsigned MEMORY_DEPTH = 64,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter logic [31:0] BASE_ADDR    = 32'h10010000
) (
   input  logic                  clk,
   input  logic                  reset,
   // Handshake: a request transfers on a rising edge where req_valid_i and req_ready_o are both 1;
   // ready is high only while idle, and request inputs are ignored at every other time.
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_write_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_unsigned_i,
   input  logic [DATA_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_error_o,
   output logic                  mem_we_o,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state, next_state;
   logic        accept;
   logic        req_err;
   logic        lat_write;
   logic [1:0]  lat_size;
   logic        lat_unsigned;
   logic [1:0]  lat_lane;
   logic [31:0] lat_wdata;
   logic [31:0] rd_word;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;
   logic [31:0] merged;

   assign accept      = req_valid_i && (state == IDLE);
   assign req_ready_o = (state == IDLE);
   assign rsp_valid_o = (state == RESP);
   assign mem_we_o    = (state == WR);
   assign dbg_state   = state;

`ifdef MEM_ADDR_CHECK_EN
   localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + 33'(4 * MEMORY_DEPTH);

   always_comb begin
      req_err = 1'b0;
      if (req_addr_i < BASE_ADDR)                       req_err = 1'b1;
      if ({1'b0, req_addr_i} >= ADDR_LIMIT)             req_err = 1'b1;
      if (req_size_i == 2'b01 && req_addr_i[0])         req_err = 1'b1;
      if (req_size_i == 2'b10 && req_addr_i[1:0] != 0)  req_err = 1'b1;
      if (req_size_i == 2'b11)                          req_err = 1'b1;
   end
`else
   assign req_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_err)           next_state = RESP;
               else if (!req_write_i) next_state = RD;
               else if (req_size_i[1]) next_state = WR;
               else                   next_state = RD;
            end
         end
         RD:      next_state = lat_write ? WR : RESP;
         WR:      next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Lane select and extension of the word arriving during RD.
   always_comb begin
      byte_sel = mem_rdata_i[{lat_lane, 3'b000} +: 8];
      half_sel = mem_rdata_i[{lat_lane[1], 4'b0000} +: 16];
      load_ext = mem_rdata_i;
      case (lat_size)
         2'b00:   load_ext = {{24{~lat_unsigned & byte_sel[7]}}, byte_sel};
         2'b01:   load_ext = {{16{~lat_unsigned & half_sel[15]}}, half_sel};
         default: load_ext = mem_rdata_i;
      endcase
   end

   // Sub-word stores patch the captured word; word stores (size 1x) send the data unchanged.
   always_comb begin
      merged = rd_word;
      case (lat_size)
         2'b00:   merged[{lat_lane, 3'b000} +: 8]     = lat_wdata[7:0];
         2'b01:   merged[{lat_lane[1], 4'b0000} +: 16] = lat_wdata[15:0];
         default: merged = lat_wdata;
      endcase
      mem_wdata_o = (state == WR) ? merged : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_write    <= 1'b0;
         lat_size     <= 2'b00;
         lat_unsigned <= 1'b0;
         lat_lane     <= 2'b00;
         lat_wdata    <= '0;
         mem_addr_o   <= '0;
         rd_word      <= '0;
         rsp_rdata_o  <= '0;
         rsp_error_o  <= 1'b0;
      end else begin
         if (accept) begin
            lat_write    <= req_write_i;
            lat_size     <= req_size_i;
            lat_unsigned <= req_unsigned_i;
            lat_lane     <= req_addr_i[1:0];
            lat_wdata    <= req_wdata_i;
            mem_addr_o   <= {req_addr_i[31:2], 2'b00};
         end
         if (state == RD) rd_word <= mem_rdata_i;
         // Only a load leaving RD enters RESP with data; everything else clears it.
         rsp_rdata_o <= (state == RD && !lat_write) ? load_ext : '0;
         rsp_error_o <= accept & req_err;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed plan steps plus random requests against an array-based
// memory reference model. Build with +define+MEM_ADDR_CHECK_EN to exercise address checking.
module tb_mem_access_ctrl;

   localparam logic [31:0] BASE = 32'h10010000;

   // Clock / reset
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [1:0]  dbg_state;

   mem_access_ctrl dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
      .rsp_error_o(rsp_error), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .dbg_state(dbg_state)
   );

   // Data_Memory stand-in: combinational read, write on rising edge.
   logic [31:0] tb_mem [64];
   assign mem_rdata = tb_mem[mem_addr[7:2]];
   always @(posedge clk) if (mem_we) tb_mem[mem_addr[7:2]] <= mem_wdata;

   // Reference model state and scoreboard
   logic [31:0] ref_mem [64];
   logic [31:0] exp_q [$];
   int tests_run = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] off, input logic uns);
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = (w >> (8 * off)) & 32'hFF;
         if (!uns && v >= 32'd128) v = v - 32'd256;
      end else if (sz == 2'd1) begin
         v = (w >> (8 * (off & 2'd2))) & 32'hFFFF;
         if (!uns && v >= 32'd32768) v = v - 32'd65536;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] off, input logic [31:0] d);
      logic [31:0] mask;
      int sh;
      if (sz == 2'd0) begin
         sh = 8 * off;
         mask = 32'hFF << sh;
      end else if (sz == 2'd1) begin
         sh = 8 * (off & 2'd2);
         mask = 32'hFFFF << sh;
      end else begin
         return d;
      end
      return (w & ~mask) | ((d << sh) & mask);
   endfunction

   // Driver + monitor for one request, checked against the model.
   task automatic txn(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input logic exp_err);
      int idx, exp_lat, exp_we_cyc, exp_we_cnt;
      int rsp_cyc, we_cyc, we_cnt;
      logic [31:0] old_w, new_w, exp_rd, rd, we_a, we_d;
      logic er;
      idx = 0; old_w = '0; new_w = '0; exp_we_cyc = 0; exp_we_cnt = 0;
      if (exp_err) begin
         exp_rd = '0;
         exp_lat = 1;
      end else begin
         idx = int'((addr - BASE) >> 2);
         old_w = ref_mem[idx];
         if (wr) begin
            new_w = model_store(old_w, sz, addr[1:0], wd);
            exp_rd = '0;
            exp_lat = (sz == 2'd0 || sz == 2'd1) ? 3 : 2;
            exp_we_cyc = exp_lat - 1;
            exp_we_cnt = 1;
         end else begin
            exp_rd = model_load(old_w, sz, addr[1:0], uns);
            exp_lat = 2;
         end
      end
      exp_q.push_back(exp_rd);

      @(negedge clk);
      check({tag, ".ready_before"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      @(posedge clk);
      rsp_cyc = 0; we_cyc = 0; we_cnt = 0; rd = '0; er = 1'b0; we_a = '0; we_d = '0;
      for (int c = 1; c <= 6 && rsp_cyc == 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            req_valid = 1'b0;
            req_addr = $urandom;
            req_wdata = $urandom;
            req_size = 2'($urandom_range(0, 3));
         end
         if (mem_we) begin
            we_cnt++; we_cyc = c; we_a = mem_addr; we_d = mem_wdata;
         end
         if (rsp_valid) begin
            rsp_cyc = c; rd = rsp_rdata; er = rsp_error;
         end
      end
      check({tag, ".rsp_cycle"}, 32'(rsp_cyc), 32'(exp_lat));
      check({tag, ".rdata"}, rd, exp_q.pop_front());
      check({tag, ".error"}, 32'(er), 32'(exp_err));
      check({tag, ".we_count"}, 32'(we_cnt), 32'(exp_we_cnt));
      if (exp_we_cnt != 0) begin
         check({tag, ".we_cycle"}, 32'(we_cyc), 32'(exp_we_cyc));
         check({tag, ".we_addr"}, we_a, {addr[31:2], 2'b00});
         check({tag, ".we_data"}, we_d, new_w);
      end
      @(negedge clk);
      check({tag, ".ready_after"}, 32'(req_ready), 32'd1);
      if (wr && !exp_err) ref_mem[idx] = new_w;
   endtask

   initial begin
      logic [31:0] v, a, w1, exp1, exp2, saved;
      logic [1:0] sz, off;
      int acc2, rc1, rc2, seen;
      logic [31:0] rd1, rd2;

      for (int i = 0; i < 64; i++) begin
         v = $urandom;
         tb_mem[i] = v;
         ref_mem[i] = v;
      end

      // Reset state
      repeat (2) @(negedge clk);
      check("rst.ready", 32'(req_ready), 32'd1);
      check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst.rdata", rsp_rdata, 32'd0);
      check("rst.error", 32'(rsp_error), 32'd0);
      check("rst.we", 32'(mem_we), 32'd0);
      check("rst.addr", mem_addr, 32'd0);
      check("rst.wdata", mem_wdata, 32'd0);
      reset = 1'b0;

      // Word store / reload
      txn("st_word", 1'b1, 2'd2, 1'b0, 32'h10010008, 32'h12345678, 1'b0);
      txn("ld_word", 1'b0, 2'd2, 1'b0, 32'h10010008, 32'h0, 1'b0);

      // Byte loads from 0x98761234
      txn("st_word2", 1'b1, 2'd2, 1'b0, 32'h10010008, 32'h98761234, 1'b0);
      txn("ld_b_s", 1'b0, 2'd0, 1'b0, 32'h1001000B, 32'h0, 1'b0);
      txn("ld_b_u", 1'b0, 2'd0, 1'b1, 32'h1001000B, 32'h0, 1'b0);
      txn("ld_b_lo", 1'b0, 2'd0, 1'b0, 32'h10010008, 32'h0, 1'b0);

      // Sub-word store and reload
      txn("st_half", 1'b1, 2'd1, 1'b0, 32'h1001000A, 32'h0000ABCD, 1'b0);
      check("st_half.mem", tb_mem[2], 32'hABCD1234);
      txn("ld_h_s", 1'b0, 2'd1, 1'b0, 32'h1001000A, 32'h0, 1'b0);

      // Misaligned / out-of-range requests
`ifdef MEM_ADDR_CHECK_EN
      txn("err_misal", 1'b0, 2'd2, 1'b0, 32'h10010006, 32'h0, 1'b1);
      txn("err_oob", 1'b1, 2'd2, 1'b0, 32'h10010100, 32'hDEADBEEF, 1'b1);
      txn("err_low", 1'b0, 2'd0, 1'b0, 32'h1000FFFF, 32'h0, 1'b1);
      txn("err_sz11", 1'b0, 2'd3, 1'b0, 32'h10010010, 32'h0, 1'b1);
`else
      txn("misal_ld", 1'b0, 2'd2, 1'b0, 32'h10010006, 32'h0, 1'b0);
      txn("half_odd", 1'b0, 2'd1, 1'b0, 32'h10010013, 32'h0, 1'b0);
      txn("sz11_ld", 1'b0, 2'd3, 1'b0, 32'h10010010, 32'h0, 1'b0);
`endif

      // Reset during the WR cycle of a sub-word store
      saved = tb_mem[3];
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'h1001000D; req_wdata = 32'h000000A5;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("rst_mid.we_before", 32'(mem_we), 32'd1);
      reset = 1'b1;
      #1;
      check("rst_mid.we_drop", 32'(mem_we), 32'd0);
      check("rst_mid.ready", 32'(req_ready), 32'd1);
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         if (rsp_valid) seen++;
         @(negedge clk);
         if (c == 1) reset = 1'b0;
      end
      check("rst_mid.no_rsp", 32'(seen), 32'd0);
      check("rst_mid.mem", tb_mem[3], ref_mem[3]);
      check("rst_mid.mem_kept", tb_mem[3], saved);

      // Back-to-back loads with valid held high
      exp1 = ref_mem[5];
      exp2 = model_load(ref_mem[6], 2'd0, 2'd1, 1'b1);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = BASE + 32'd20;
      @(posedge clk);
      acc2 = 0; rc1 = 0; rc2 = 0; rd1 = '0; rd2 = '0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) begin
            req_size = 2'd0; req_unsigned = 1'b1; req_addr = BASE + 32'd25;
         end
         if (acc2 != 0 && c == acc2 + 1) req_valid = 1'b0;
         if (rsp_valid) begin
            if (rc1 == 0) begin rc1 = c; rd1 = rsp_rdata; end
            else begin rc2 = c; rd2 = rsp_rdata; end
         end
         if (req_ready && acc2 == 0) acc2 = c;
      end
      req_valid = 1'b0;
      check("b2b.accept2_cycle", 32'(acc2), 32'd3);
      check("b2b.rsp1_cycle", 32'(rc1), 32'd2);
      check("b2b.rsp2_cycle", 32'(rc2), 32'd5);
      check("b2b.rdata1", rd1, exp1);
      check("b2b.rdata2", rd2, exp2);

      // Random aligned in-range traffic
      for (int n = 0; n < 40; n++) begin
         sz = 2'($urandom_range(0, 2));
         off = 2'($urandom_range(0, 3));
         if (sz == 2'd1) off = off & 2'd2;
         if (sz == 2'd2) off = 2'd0;
         a = BASE + 32'($urandom_range(0, 63)) * 32'd4 + 32'(off);
         w1 = $urandom;
         txn("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, w1, 1'b0);
      end

      for (int i = 0; i < 64; i++) check("final_mem", tb_mem[i], ref_mem[i]);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store access controller sitting directly upstream of `Data_Memory`. It accepts one byte, halfword or word request at a time from the execute stage over a valid/ready handshake. It translates each request into word-wide memory cycles, performing read-modify-write for sub-word stores. It returns sign- or zero-extended load data with a one-cycle response pulse.

## Interface
Parameters:
- `MEMORY_DEPTH`, 64: words in the downstream `Data_Memory`.
- `DATA_WIDTH`, 32: data and address width; only 32 is supported.
- `BASE_ADDR`, 32'h10010000: first byte address of the data segment.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  controller idle, request can be accepted.
- `req_write_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned_i`  in  1  1 = zero-extend loads, 0 = sign-extend.
- `req_addr_i`  in  32  byte address.
- `req_wdata_i`  in  32  store data, right-justified.
- `rsp_valid_o`  out  1  one-cycle completion pulse.
- `rsp_rdata_o`  out  32  extended load data; 0 for stores and errors.
- `rsp_error_o`  out  1  request rejected.
- `mem_we_o`  out  1  to `Write_Enable_i`.
- `mem_addr_o`  out  32  to `Address_i`, always word-aligned.
- `mem_wdata_o`  out  32  to `Write_Data_i`.
- `mem_rdata_i`  in  32  from `Read_Data_o`. The memory has a combinational read and writes on the rising edge while `mem_we_o`=1.

## Operation
- FSM states: IDLE, RD, WR, RESP.
- `req_ready_o` = 1 only in IDLE. A request is accepted on a clk edge with `req_valid_i`&`req_ready_o`. Acceptance latches write, size, unsigned, address, wdata and error.
- Accept transitions:
  - errored request → RESP;
  - load → RD;
  - word store → WR;
  - byte/half store → RD.
- RD: `mem_we_o`=0. `mem_rdata_i` is captured at the end of the cycle. A load goes → RESP; a store goes → WR.
- WR: `mem_we_o`=1 for exactly this cycle, then → RESP. `mem_wdata_o` carries the full `req_wdata_i` for word stores, or the captured word with the target lane replaced.
- RESP: `rsp_valid_o`=1 for exactly this cycle, then → IDLE.
- Lane placement is little-endian:
  - byte lane = `addr[1:0]`, bits [8*lane+7 : 8*lane];
  - half lane = `addr[1]`, bits [16*lane+15 : 16*lane].
- Load extension: bit 7 (byte) or bit 15 (half) of the selected lane is replicated when `req_unsigned_i`=0; zeros are filled otherwise.
- `mem_addr_o` = {latched `addr[31:2]`, 2'b00}, registered at acceptance and held until the next acceptance.
- `mem_we_o` is a decode of state WR only, so reset deasserts it asynchronously.
- Response data and error are registered and hold 0 outside RESP.

## Timing
- Cycle 0 = the acceptance cycle.
- Load: RD in cycle 1, `rsp_valid_o` in cycle 2.
- Word store: write edge at the end of cycle 1, `rsp_valid_o` in cycle 2.
- Sub-word store: RD in cycle 1, write edge at the end of cycle 2, `rsp_valid_o` in cycle 3.
- Errored request: `rsp_valid_o` in cycle 1, no memory cycle.
- `req_ready_o` returns high the cycle after RESP. Minimum request spacing is 3 cycles for a load and 4 for a sub-word store.
- Reset values: state IDLE, `req_ready_o`=1, and all other outputs 0.
- Reset mid-operation: the request is abandoned with no response. If reset hits WR before the clock edge, no write occurs.
- A `req_valid_i` deassert outside IDLE is ignored. Inputs are sampled only at acceptance.

## Configuration
- Macro `MEM_ADDR_CHECK_EN`.
- Defined: a request is errored when any of the following holds:
  - address < `BASE_ADDR`;
  - address ≥ `BASE_ADDR`+4*`MEMORY_DEPTH`;
  - a half access with `addr[0]`=1;
  - a word access with `addr[1:0]`≠0;
  - `req_size_i`=11.
  
  An errored request gives `rsp_error_o`=1 with RESP, and `mem_we_o` is never asserted.
- Undefined: `rsp_error_o` is tied to 0. Misaligned low bits are ignored: a half access uses `addr[1]` only and a word access ignores `addr[1:0]`. Size 11 is treated as a word. Out-of-range addresses are passed through.

## Test plan
- Word store: reset, then store word 0x12345678 at 0x10010008. Required: `mem_we_o`=1 in cycle 1 with addr 0x10010008 and data 0x12345678; `rsp_valid_o` in cycle 2. A following load word returns 0x12345678.
- Byte loads: memory[0x10010008]=0x98761234. Signed byte load at 0x1001000B → 0xFFFFFF98; unsigned → 0x00000098. Byte load at 0x10010008 → 0x00000034.
- Sub-word store: store half 0xABCD at 0x1001000A onto 0x98761234. Required: RD cycle 1, WR cycle 2 with `mem_wdata_o`=0xABCD1234, `rsp_valid_o` cycle 3. A signed half reload → 0xFFFFABCD.
- Address check, with `MEM_ADDR_CHECK_EN`: load word at 0x10010006 and store at 0x10010100 each give `rsp_valid_o`&`rsp_error_o` in cycle 1, with `mem_we_o` never high. Without the macro, the 0x10010006 load returns the word at 0x10010004.
- Reset mid-store: assert `reset` in cycle 2 of a sub-word store. Required: `mem_we_o` drops immediately, memory is unchanged, `req_ready_o`=1, and no `rsp_valid_o`.
- Back-to-back requests: hold `req_valid_i` high with two loads. The second is accepted only in the first IDLE cycle after RESP.
